uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter downstream of the BF core's output-write path (clk3 & cout strobe, new_ram_val, ram_addr).
- Replaces the direct byte-to-uart path. Output bursts from the slow divided-clock core are queued, then serialized on the fast board clock.
- Runs entirely in the `clk` domain. The write strobe is synchronized and edge-detected internally.

---
 rtl/uart_tx_pkg.sv | 8 +
 rtl/byte_fifo.sv | 37 +++
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 tb/tb_uart_tx_fifo.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type and sizing helpers for the buffered UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int FRAME_DATA_BITS = 8;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular byte queue with registered count and combinational head output
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: strobe-synchronized byte queue feeding an 8N1 UART serializer.
// Define UART_TX_PARITY_EN to append an even parity bit (8E1 frame).
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  TX_ADDR      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t POST_DATA = PARITY;
  logic par;
`else
  localparam tx_state_t POST_DATA = STOP;
`endif
  tx_state_t state, nxt;
  logic s1, s2, prev, push, pop, wrap, tx_d, busy_d;
  logic [7:0] head, shift_reg;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [AW:0] count;
  assign push = s2 & ~prev & (wr_addr == TX_ADDR);
  assign wrap = baud == CW'(CLKS_PER_BIT - 1);
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(wr_data), .pop(pop),
    .dout(head), .empty(fifo_empty), .full(fifo_full), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, prev} <= '0;
      overflow <= 1'b0;
    end else begin
      {s1, s2, prev} <= {wr_valid, s1, s2};
      overflow <= (push && count == (AW+1)'(FIFO_DEPTH)) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fifo_empty ? IDLE : START;
      START:   nxt = wrap ? DATA : START;
      DATA:    nxt = (wrap && bit_idx == 3'(FRAME_DATA_BITS - 1)) ? POST_DATA : DATA;
      PARITY:  nxt = wrap ? STOP : PARITY;
      STOP:    nxt = !wrap ? STOP : fifo_empty ? IDLE : START;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    pop = !fifo_empty && (state == IDLE || (state == STOP && wrap));
    busy_d = state != IDLE;
`ifdef UART_TX_PARITY_EN
    tx_d = state == START ? 1'b0 : state == DATA ? shift_reg[0] : state == PARITY ? par : 1'b1;
`else
    tx_d = state == START ? 1'b0 : state == DATA ? shift_reg[0] : 1'b1;
`endif
  end
  // tx/busy are registered copies of the state outputs, so the line lags the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      baud <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      tx <= tx_d;
      busy <= busy_d;
      if (pop) begin
        shift_reg <= head;
        baud <= '0;
`ifdef UART_TX_PARITY_EN
        par <= ^head;
`endif
      end else if (state != IDLE) begin
        baud <= wrap ? '0 : baud + 1'b1;
        if (wrap && state == START) bit_idx <= '0;
        if (wrap && state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a byte scoreboard checked by a serial-line monitor
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_addr = '0, wr_data = '0;
  logic tx, busy, fifo_empty, fifo_full, overflow;
  logic mon_en = 1'b1;
  logic [7:0] sb[$];
  int starts[$];
  int checks = 0, errors = 0, cyc = 0, frames = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input logic [7:0] a, input logic [7:0] d, input int hi, input int lo, input logic exp);
    wr_addr = a;
    wr_data = d;
    wr_valid = 1'b1;
    if (exp) sb.push_back(d);
    cycles(hi);
    wr_valid = 1'b0;
    cycles(lo);
  endtask
  // samples each bit mid-cell, starting from the first low cycle of the start bit
  initial begin : monitor
    logic [7:0] b;
    logic [8:0] e;
    logic st0, sp, pb;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        starts.push_back(cyc);
        cycles(CPB / 2);
        st0 = tx;
        for (int i = 0; i < 8; i++) begin
          cycles(CPB);
          b[i] = tx;
        end
        pb = 1'b0;
`ifdef UART_TX_PARITY_EN
        cycles(CPB);
        pb = tx;
`endif
        cycles(CPB);
        sp = tx;
        cycles(CPB - CPB / 2 - 1);
        frames++;
        if (mon_en) begin
          e = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'bx;
          chk("start_bit", 32'(st0), 32'd0);
          chk("rx_byte", 32'(b), 32'(e));
          chk("stop_bit", 32'(sp), 32'd1);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", 32'(pb), 32'(^e[7:0]));
`endif
        end
      end
    end
  end
  initial begin
    int c0, k, nb, bad;
    cycles(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    cycles(2);
    c0 = cyc;
    wr_addr = 8'h00;
    wr_data = 8'hA5;
    wr_valid = 1'b1;
    sb.push_back(8'hA5);
    cycles(2);
    chk("empty_before_push", 32'(fifo_empty), 32'd1);
    cycles(1);
    chk("empty_after_push", 32'(fifo_empty), 32'd0);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (i == 36) wr_valid = 1'b0;
      nb += int'(busy === 1'b1);
    end
    chk("single_frames", 32'(frames), 32'd1);
    chk("busy_len", 32'(nb), 32'(FRAME));
    chk("start_latency", 32'(starts[0] - c0), 32'd5);
    bad = 0;
    wr_addr = 8'h01;
    wr_data = 8'h55;
    wr_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (i == 10) wr_valid = 1'b0;
      bad += int'(fifo_empty !== 1'b1 || tx !== 1'b1);
    end
    chk("addr_filter", 32'(bad), 32'd0);
    chk("addr_frames", 32'(frames), 32'd1);
    k = frames;
    strobe(8'h00, 8'h48, 5, 5, 1'b1);
    strobe(8'h00, 8'h69, 5, 5, 1'b1);
    strobe(8'h00, 8'h0A, 5, 5, 1'b1);
    cycles(3 * FRAME + 20);
    chk("burst_frames", 32'(frames), 32'(k + 3));
    chk("burst_gap1", 32'(starts[k+1] - starts[k]), 32'(FRAME));
    chk("burst_gap2", 32'(starts[k+2] - starts[k+1]), 32'(FRAME));
    chk("burst_drained", 32'(sb.size()), 32'd0);
    k = frames;
    for (int i = 0; i < 6; i++)
      strobe(8'h00, 8'h10 + 8'(i), 3, 3, i < 5);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    cycles(5 * FRAME + 20);
    chk("ovf_frames", 32'(frames), 32'(k + 5));
    chk("ovf_drained", 32'(sb.size()), 32'd0);
`ifdef UART_TX_PARITY_EN
    k = frames;
    strobe(8'h00, 8'h07, 3, 3, 1'b1);
    strobe(8'h00, 8'h03, 3, 3, 1'b1);
    cycles(2 * FRAME + 20);
    chk("par_frames", 32'(frames), 32'(k + 2));
    chk("par_frame_len", 32'(starts[k+1] - starts[k]), 32'(11 * CPB));
`endif
    mon_en = 1'b0;
    strobe(8'h00, 8'hC3, 3, 7, 1'b0);
    strobe(8'h00, 8'h3C, 3, 3, 1'b0);
    cycles(6);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    chk("midrst_full", 32'(fifo_full), 32'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      cycles(1);
      bad += int'(tx !== 1'b1 || busy !== 1'b0);
    end
    chk("midrst_quiet", 32'(bad), 32'd0);
    mon_en = 1'b1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
